// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: data widths, physical-register tag width and the
// broadcast packet carried on the common data bus.
package cdb_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int PREG_NUMBER = 64;
  localparam int PRW         = $clog2(PREG_NUMBER);

  typedef struct packed {
    logic            valid;
    logic [PRW-1:0]  tag;
    logic [XLEN-1:0] value;
  } cdb_packet_t;

  localparam int CDB_WIDTH = 1 + PRW + XLEN;

endpackage

// File: rtl/cdb_arbiter_picker.sv
// Combinational round-robin picker: rotate the request vector by ptr,
// find the first set bit, then map the offset back to an absolute index.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [PW-1:0]  off_s;
  logic [PW:0]    sum_s;

  // Rotate, find-first-set from the pointer, unrotate modulo N
  always_comb begin
    dbl_s = {req, req} >> ptr;
    rot_s = dbl_s[N-1:0];
    off_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? PW'(i) : off_s;
    end
    any   = |rot_s;
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    if (sum_s >= (PW+1)'(N)) begin
      gnt_idx = PW'(sum_s - (PW+1)'(N));
    end else begin
      gnt_idx = sum_s[PW-1:0];
    end
    gnt = '0;
    if (any) begin
      gnt[gnt_idx] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Complete-stage arbiter: grants one done FU per cycle (starvation-forced
// or round-robin) and broadcasts its tag/value on the CDB one cycle later.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_FU-1:0]      fu_done_i,
  input  logic [NUM_FU*PRW-1:0]  fu_dest_reg_i,
  input  logic [NUM_FU*XLEN-1:0] fu_result_i,
  input  logic                   cdb_stall_i,
  input  logic                   branch_recover_i,
  output logic [NUM_FU-1:0]      complete_en_o,
  output logic                   cdb_valid_o,
  output logic [PRW-1:0]         cdb_tag_o,
  output logic [XLEN-1:0]        cdb_value_o,
  output logic                   starve_o
);

  localparam int PW = $clog2(NUM_FU);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [PW-1:0]     rr_ptr_r;
  logic [CW-1:0]     wait_cnt_r [NUM_FU];
  cdb_packet_t       cdb_r;

  logic              grant_ok_s;
  logic [NUM_FU-1:0] starved_s;
  logic [NUM_FU-1:0] rr_gnt_s;
  logic [NUM_FU-1:0] grant_s;
  logic [PW-1:0]     rr_idx_s;
  logic [PW-1:0]     forced_idx_s;
  logic [PW-1:0]     win_idx_s;
  logic              rr_any_s;
  logic              forced_any_s;

  rr_picker #(.N(NUM_FU), .PW(PW)) u_rr_picker (
    .req     (fu_done_i),
    .ptr     (rr_ptr_r),
    .gnt     (rr_gnt_s),
    .gnt_idx (rr_idx_s),
    .any     (rr_any_s)
  );

  // Starved candidates and the lowest-index one among them
  always_comb begin
    starved_s    = '0;
    forced_idx_s = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      starved_s[i] = fu_done_i[i] && (wait_cnt_r[i] >= CNT_MAX);
    end
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      forced_idx_s = starved_s[i] ? PW'(i) : forced_idx_s;
    end
    forced_any_s = |starved_s;
  end

  // Grant select: recover/stall/reset block, forced priority beats round-robin
  always_comb begin
    grant_ok_s = !reset && !branch_recover_i && !cdb_stall_i;
    grant_s    = '0;
    win_idx_s  = '0;
    starve_o   = 1'b0;
    if (grant_ok_s && forced_any_s) begin
      win_idx_s               = forced_idx_s;
      grant_s[forced_idx_s]   = 1'b1;
      starve_o                = 1'b1;
    end else if (grant_ok_s && rr_any_s) begin
      win_idx_s = rr_idx_s;
      grant_s   = rr_gnt_s;
    end else begin
      grant_s   = '0;
    end
  end

  assign complete_en_o = grant_s;

  // Round-robin pointer moves just past the winner; holds without a grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else if (|grant_s) begin
      rr_ptr_r <= (win_idx_s == PW'(NUM_FU - 1)) ? '0 : win_idx_s + PW'(1);
    end
  end

  // Per-FU wait counters; a stall still ages a waiting FU
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wait_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (branch_recover_i || grant_s[i] || !fu_done_i[i]) begin
          wait_cnt_r[i] <= '0;
        end else if (wait_cnt_r[i] != CNT_MAX) begin
          wait_cnt_r[i] <= wait_cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // Broadcast register; tag/value hold when nothing is granted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_r <= '0;
    end else begin
      cdb_r.valid <= |grant_s;
      if (|grant_s) begin
        cdb_r.tag   <= fu_dest_reg_i[win_idx_s*PRW +: PRW];
        cdb_r.value <= fu_result_i[win_idx_s*XLEN +: XLEN];
      end
    end
  end

  // A recover squashes the in-flight broadcast in its own cycle
  assign cdb_valid_o = cdb_r.valid && !branch_recover_i;
  assign cdb_tag_o   = cdb_r.tag;
  assign cdb_value_o = cdb_r.value;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, round-robin, wrap, starvation,
// stall and recover, with per-cycle protocol checks.
module tb_cdb_arbiter;

  localparam int NF = 4;
  localparam int PRW = 6;
  localparam int XL = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NF-1:0]    fu_done;
  logic [NF*PRW-1:0] fu_dest_reg;
  logic [NF*XL-1:0] fu_result;
  logic             cdb_stall;
  logic             branch_recover;
  logic [NF-1:0]    complete_en;
  logic             cdb_valid;
  logic [PRW-1:0]   cdb_tag;
  logic [XL-1:0]    cdb_value;
  logic             starve;
  logic             rec_q = 1'b0;

  int checks = 0;
  int failures = 0;

  localparam logic [XL-1:0] R0 = 32'h1111_0000;
  localparam logic [XL-1:0] R1 = 32'h2222_0001;
  localparam logic [XL-1:0] R2 = 32'h3333_0002;
  localparam logic [XL-1:0] R3 = 32'hDEAD_BEEF;

  cdb_arbiter #(.NUM_FU(NF), .STARVE_MAX(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .fu_done_i        (fu_done),
    .fu_dest_reg_i    (fu_dest_reg),
    .fu_result_i      (fu_result),
    .cdb_stall_i      (cdb_stall),
    .branch_recover_i (branch_recover),
    .complete_en_o    (complete_en),
    .cdb_valid_o      (cdb_valid),
    .cdb_tag_o        (cdb_tag),
    .cdb_value_o      (cdb_value),
    .starve_o         (starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [NF-1:0] d, input logic s, input logic r);
    @(posedge clk);
    #1;
    fu_done        = d;
    cdb_stall      = s;
    branch_recover = r;
    @(negedge clk);
  endtask

  always @(posedge clk) rec_q <= branch_recover;

  always @(negedge clk) begin
    if (!reset) begin
      chk("onehot0", 64'($onehot0(complete_en)), 64'd1);
      chk("en_implies_done", 64'(complete_en & ~fu_done), 64'd0);
      if (rec_q) chk("valid_after_recover", 64'(cdb_valid), 64'd0);
    end
  end

  initial begin
    reset          = 1'b1;
    fu_done        = 4'b0000;
    cdb_stall      = 1'b0;
    branch_recover = 1'b0;
    fu_dest_reg    = {6'd8, 6'd7, 6'd6, 6'd5};
    fu_result      = {R3, R2, R1, R0};

    #2;
    fu_done = 4'b1111;
    #1;
    chk("rst_en", 64'(complete_en), 64'd0);
    chk("rst_starve", 64'(starve), 64'd0);
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_tag", 64'(cdb_tag), 64'd0);
    chk("rst_value", 64'(cdb_value), 64'd0);

    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("s1_first_en", 64'(complete_en), 64'b0001);
    step(4'b1111, 1'b0, 1'b0);
    chk("s1_second_en", 64'(complete_en), 64'b0010);
    chk("s1_tag", 64'(cdb_tag), 64'd5);

    // Reset mid-cycle, away from any edge
    @(posedge clk); #3; reset = 1'b1; #1;
    chk("mid_rst_en", 64'(complete_en), 64'd0);
    chk("mid_rst_valid", 64'(cdb_valid), 64'd0);
    chk("mid_rst_tag", 64'(cdb_tag), 64'd0);
    chk("mid_rst_value", 64'(cdb_value), 64'd0);
    chk("mid_rst_starve", 64'(starve), 64'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("post_rst_en", 64'(complete_en), 64'b0001);
    chk("post_rst_valid", 64'(cdb_valid), 64'd0);

    // Round-robin sweep
    step(4'b1111, 1'b0, 1'b0);
    chk("rr_en1", 64'(complete_en), 64'b0010);
    chk("rr_valid1", 64'(cdb_valid), 64'd1);
    chk("rr_tag1", 64'(cdb_tag), 64'd5);
    chk("rr_val1", 64'(cdb_value), 64'(R0));
    step(4'b1111, 1'b0, 1'b0);
    chk("rr_en2", 64'(complete_en), 64'b0100);
    chk("rr_tag2", 64'(cdb_tag), 64'd6);
    step(4'b1111, 1'b0, 1'b0);
    chk("rr_en3", 64'(complete_en), 64'b1000);
    chk("rr_tag3", 64'(cdb_tag), 64'd7);
    step(4'b0000, 1'b0, 1'b0);
    chk("rr_en_idle", 64'(complete_en), 64'd0);
    chk("rr_valid4", 64'(cdb_valid), 64'd1);
    chk("rr_tag4", 64'(cdb_tag), 64'd8);
    chk("rr_val4", 64'(cdb_value), 64'(R3));

    // Wrap from pointer 3 back to 0
    step(4'b0100, 1'b0, 1'b0);
    chk("wrap_setup_en", 64'(complete_en), 64'b0100);
    step(4'b1001, 1'b0, 1'b0);
    chk("wrap_en3", 64'(complete_en), 64'b1000);
    chk("wrap_tag2", 64'(cdb_tag), 64'd7);
    step(4'b0001, 1'b0, 1'b0);
    chk("wrap_en0", 64'(complete_en), 64'b0001);
    chk("wrap_val3", 64'(cdb_value), 64'(R3));
    step(4'b0000, 1'b0, 1'b0);
    chk("wrap_val0", 64'(cdb_value), 64'(R0));
    chk("wrap_tag0", 64'(cdb_tag), 64'd5);

    // Starvation: FU0 held, others win, stalls age FU0 to the limit
    step(4'b0111, 1'b0, 1'b0);
    chk("stv_c0_en", 64'(complete_en), 64'b0010);
    step(4'b0101, 1'b0, 1'b0);
    chk("stv_c1_en", 64'(complete_en), 64'b0100);
    for (int c = 2; c <= 6; c++) begin
      step(4'b0001, 1'b1, 1'b0);
      chk("stv_stall_en", 64'(complete_en), 64'd0);
      chk("stv_stall_starve", 64'(starve), 64'd0);
    end
    chk("stv_stall_valid", 64'(cdb_valid), 64'd0);
    step(4'b1001, 1'b0, 1'b0);
    chk("stv_c7_en", 64'(complete_en), 64'b1000);
    chk("stv_c7_starve", 64'(starve), 64'd0);
    step(4'b0001, 1'b0, 1'b0);
    chk("stv_c8_en", 64'(complete_en), 64'b0001);
    chk("stv_c8_starve", 64'(starve), 64'd1);
    step(4'b0000, 1'b0, 1'b0);
    chk("stv_c9_starve", 64'(starve), 64'd0);
    chk("stv_c9_valid", 64'(cdb_valid), 64'd1);
    chk("stv_c9_tag", 64'(cdb_tag), 64'd5);

    // Stall holds off FU2 for three cycles
    for (int c = 0; c < 3; c++) begin
      step(4'b0100, 1'b1, 1'b0);
      chk("stall_en", 64'(complete_en), 64'd0);
      chk("stall_valid", 64'(cdb_valid), 64'd0);
    end
    step(4'b0100, 1'b0, 1'b0);
    chk("stall_release_en", 64'(complete_en), 64'b0100);

    // Recover while the broadcast register holds a valid packet
    step(4'b1000, 1'b0, 1'b1);
    chk("rec_valid_same", 64'(cdb_valid), 64'd0);
    chk("rec_en", 64'(complete_en), 64'd0);
    step(4'b0000, 1'b0, 1'b0);
    chk("rec_valid_next", 64'(cdb_valid), 64'd0);
    chk("rec_tag_hold", 64'(cdb_tag), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
